// File: rtl/dc_token_pkg.sv
// rtl/dc_token_pkg.sv - shared types, constants and popcount for the token-based dual-clock channel
package dc_token_pkg;

    localparam int DC_TOKEN_SYNC_MIN        = 2;
    localparam int DC_TOKEN_DEF_BUFFER_WIDTH = 8;

    typedef logic [$clog2(DC_TOKEN_DEF_BUFFER_WIDTH)-1:0]   slot_idx_t;
    typedef logic [$clog2(DC_TOKEN_DEF_BUFFER_WIDTH+1)-1:0] fill_t;

    // Vectors up to 64 bits; callers zero-extend narrower token vectors.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dc_token_sync.sv
// rtl/dc_token_sync.sv - N-bit, STAGES-deep asynchronous-reset synchroniser chain
module dc_token_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int s = 0; s < STAGES; s++) begin
                chain[s] <= '0;
            end
        end else begin
            chain[0] <= d_i;
            for (int s = 1; s < STAGES; s++) begin
                chain[s] <= chain[s-1];
            end
        end
    end

    assign q_o = chain[STAGES-1];

endmodule

// File: rtl/dc_token_rx_channel.sv
// rtl/dc_token_rx_channel.sv - reader end of the token dual-clock channel; DC_TOKEN_RX_FILL_EN adds fill_o
module dc_token_rx_channel
    import dc_token_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_WIDTH = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic [BUFFER_WIDTH-1:0]            writetoken_i,
    input  logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_async_i,
    output logic [BUFFER_WIDTH-1:0]            readpointer_o,
    output logic [DATA_WIDTH-1:0]              data_o,
    output logic                               valid_o,
`ifdef DC_TOKEN_RX_FILL_EN
    output logic [$clog2(BUFFER_WIDTH+1)-1:0]  fill_o,
`endif
    input  logic                               ready_i
);

    localparam int IDX_W  = $clog2(BUFFER_WIDTH);
    localparam int STAGES = (SYNC_STAGES < DC_TOKEN_SYNC_MIN) ? DC_TOKEN_SYNC_MIN : SYNC_STAGES;

    logic [BUFFER_WIDTH-1:0] wt_sync;
    logic [BUFFER_WIDTH-1:0] rp_q;
    logic [IDX_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]   slots [BUFFER_WIDTH];
    logic                    slot_full;
    logic                    pop;

    dc_token_sync #(
        .WIDTH  (BUFFER_WIDTH),
        .STAGES (STAGES)
    ) u_wt_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (writetoken_i),
        .q_o    (wt_sync)
    );

    for (genvar i = 0; i < BUFFER_WIDTH; i++) begin : g_slot
        assign slots[i] = data_async_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // A slot is full while the writer's toggle parity differs from ours.
    assign slot_full = wt_sync[rd_idx] ^ rp_q[rd_idx];
    assign pop       = slot_full && (!valid_o || ready_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rp_q    <= '0;
            rd_idx  <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (pop) begin
            data_o         <= slots[rd_idx];
            valid_o        <= 1'b1;
            rp_q[rd_idx]   <= ~rp_q[rd_idx];
            rd_idx         <= rd_idx + 1'b1;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

    assign readpointer_o = rp_q;

`ifdef DC_TOKEN_RX_FILL_EN
    localparam int FILL_W = $clog2(BUFFER_WIDTH+1);

    // Occupancy counts slots still in the buffer plus the beat held on data_o.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fill_o <= '0;
        end else begin
            fill_o <= FILL_W'(popcount(64'(wt_sync ^ rp_q))) + FILL_W'(valid_o);
        end
    end
`endif

endmodule

// File: tb/tb_dc_token_rx_channel.sv
// tb/tb_dc_token_rx_channel.sv - scoreboard bench for dc_token_rx_channel (optionally with DC_TOKEN_RX_FILL_EN)
module tb_dc_token_rx_channel;
    import dc_token_pkg::*;

    localparam int DW = 32;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic [BW-1:0] wt;
    logic [BW*DW-1:0] data_async;
    logic [BW-1:0] readpointer;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
`ifdef DC_TOKEN_RX_FILL_EN
    fill_t         fill;
`endif

    logic [DW-1:0] slot_data [BW];
    logic [DW-1:0] exp_q [$];
    slot_idx_t     w_idx;
    int            written;
    int            accepted;
    int            n_cmp;
    int            n_err;

    always #5 clk = ~clk;

    always_comb begin
        data_async = '0;
        for (int i = 0; i < BW; i++) data_async[i*DW +: DW] = slot_data[i];
    end

    dc_token_rx_channel #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW), .SYNC_STAGES(2)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .writetoken_i  (wt),
        .data_async_i  (data_async),
        .readpointer_o (readpointer),
        .data_o        (data),
        .valid_o       (valid),
`ifdef DC_TOKEN_RX_FILL_EN
        .fill_o        (fill),
`endif
        .ready_i       (ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Slot i has been freed once per completed lap plus once if the partial lap reached it.
    function automatic logic [BW-1:0] rp_expect(input int pops);
        logic [BW-1:0] r;
        for (int i = 0; i < BW; i++) r[i] = 1'((pops / BW + ((i < pops % BW) ? 1 : 0)) % 2);
        return r;
    endfunction

    // Monitor: pops the scoreboard on every accepted beat and checks hold stability.
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 64'(valid), 64'(1));
                check("hold_data", 64'(data), 64'(prev_data));
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("beat_data", 64'(data), 64'(exp_q.pop_front()));
                end
                accepted++;
            end
            prev_hold = valid && !ready;
            prev_data = data;
        end
    end

    task automatic writer_reset();
        wt = '0;
        w_idx = '0;
        written = 0;
        exp_q.delete();
        for (int i = 0; i < BW; i++) slot_data[i] = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        writer_reset();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    // Writer model: fills the next slot once its readpointer parity shows it free.
    task automatic write_slot(input logic [DW-1:0] d);
        int budget;
        budget = 0;
        while (readpointer[w_idx] != wt[w_idx] && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 200) check("writer_timeout", 64'(budget), 64'(0));
        slot_data[w_idx] = d;
        wt[w_idx] = ~wt[w_idx];
        exp_q.push_back(d);
        w_idx = w_idx + 1'b1;
        written++;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || valid) && budget < 500) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 500) check("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int base;
        int budget;
        logic [BW-1:0] rp_hold;
        n_cmp = 0; n_err = 0; accepted = 0;
        rstn = 1'b0; ready = 1'b0;
        writer_reset();
        #12;
        check("reset_valid", 64'(valid), 64'(0));
        check("reset_rp", 64'(readpointer), 64'(0));
        check("reset_data", 64'(data), 64'(0));
`ifdef DC_TOKEN_RX_FILL_EN
        check("reset_fill", 64'(fill), 64'(0));
`endif
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Single beat: three edges from token toggle to valid.
        ready = 1'b1;
        slot_data[0] = 32'hDEADBEEF;
        wt[0] = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        w_idx = 1; written = 1;
        @(posedge clk); #1 check("lat_edge1", 64'(valid), 64'(0));
        @(posedge clk); #1 check("lat_edge2", 64'(valid), 64'(0));
        @(posedge clk); #1 check("lat_edge3_valid", 64'(valid), 64'(1));
        check("single_data", 64'(data), 64'h0000_0000_DEAD_BEEF);
        @(posedge clk); #1 check("single_valid_drop", 64'(valid), 64'(0));
        check("single_rp", 64'(readpointer), 64'(rp_expect(1)));

        // Wrap-around: ten beats reuse slots 0 and 1.
        do_reset();
        for (int b = 0; b < 10; b++) write_slot(DW'(b));
        drain();
        check("wrap_rp", 64'(readpointer), 64'(rp_expect(10)));
        check("wrap_rp_const", 64'(readpointer), 64'hFC);

        // Backpressure: eight full slots, consumer stalled.
        do_reset();
        ready = 1'b0;
        for (int b = 0; b < BW; b++) write_slot(32'h1000_0000 + DW'(b));
        repeat (20) @(posedge clk);
        #1;
        check("bp_rp", 64'(readpointer), 64'(rp_expect(1)));
        check("bp_valid", 64'(valid), 64'(1));
        check("bp_data", 64'(data), 64'h1000_0000);
`ifdef DC_TOKEN_RX_FILL_EN
        check("bp_fill", 64'(fill), 64'(8));
`endif

        // Full throughput from the backpressured state.
        ready = 1'b1;
        for (int k = 0; k < BW; k++) begin
            check("thru_valid", 64'(valid), 64'(1));
            @(posedge clk); #1;
        end
        check("thru_end_valid", 64'(valid), 64'(0));
        check("thru_rp", 64'(readpointer), 64'(rp_expect(8)));

        // Asynchronous reset after three beats have been accepted.
        do_reset();
        ready = 1'b0;
        for (int b = 0; b < BW; b++) write_slot(32'h2000_0000 + DW'(b));
        base = accepted;
        ready = 1'b1;
        budget = 0;
        while (accepted < base + 3 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        if (budget >= 100) check("mid_timeout", 64'(accepted - base), 64'(3));
        #2 rstn = 1'b0;
        #1;
        check("mid_valid", 64'(valid), 64'(0));
        check("mid_rp", 64'(readpointer), 64'(0));
`ifdef DC_TOKEN_RX_FILL_EN
        check("mid_fill", 64'(fill), 64'(0));
`endif
        writer_reset();
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        write_slot(32'hA5A5_0000);
        write_slot(32'hA5A5_0001);
        drain();
        check("mid_restart_rp", 64'(readpointer), 64'(rp_expect(2)));

        // Idle: no token activity.
        rp_hold = readpointer;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (valid !== 1'b0 || readpointer !== rp_hold) begin
                check("idle_valid", 64'(valid), 64'(0));
                check("idle_rp", 64'(readpointer), 64'(rp_hold));
            end
        end
        check("idle_end_rp", 64'(readpointer), 64'(rp_hold));

        // Randomized traffic with random consumer stalls and writer gaps.
        do_reset();
        fork
            begin
                for (int c = 0; c < 400; c++) begin
                    @(posedge clk); #1 ready = ($urandom_range(0, 3) != 0);
                end
                ready = 1'b1;
            end
            begin
                for (int b = 0; b < 60; b++) begin
                    write_slot($urandom);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
            end
        join
        drain();
        check("rand_rp", 64'(readpointer), 64'(rp_expect(written)));
        check("rand_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
